// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter for the EX stage: SRL/SRA/SLL/ROTR done as repeated right
// shifts of at most STEP bits; SLL reverses the operand going in and the result coming out.
module shift_unit_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result
);

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SLL  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [1:0] FILL_ZERO = 2'd0;
    localparam logic [1:0] FILL_SIGN = 2'd1;
    localparam logic [1:0] FILL_ROT  = 2'd2;

    localparam logic [SHAMT_WIDTH:0]   STEP_W  = (SHAMT_WIDTH+1)'(STEP);
    localparam logic [SHAMT_WIDTH+1:0] WIDTH_W = (SHAMT_WIDTH+2)'(DATA_WIDTH);

    logic [1:0]             state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [SHAMT_WIDTH-1:0] rem;
    logic                   rev_flag;
    logic [1:0]             mode;
    logic                   fill_bit;

    logic [DATA_WIDTH-1:0]  data_rev;
    logic [DATA_WIDTH-1:0]  operand;
    logic [DATA_WIDTH-1:0]  acc_rev;
    logic [DATA_WIDTH-1:0]  acc_out;
    logic [1:0]             fill_sel;
    logic [SHAMT_WIDTH:0]   k;
    logic [SHAMT_WIDTH+1:0] k_comp;
    logic [DATA_WIDTH-1:0]  hi_word;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [SHAMT_WIDTH-1:0] rem_next;

    assign busy = (state != ST_IDLE);

    // Bit-reversal stages: pure wiring plus a select, no added latency.
    always_comb begin
        data_rev = '0;
        acc_rev  = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            data_rev[i] = data_in[DATA_WIDTH-1-i];
            acc_rev[i]  = acc[DATA_WIDTH-1-i];
        end
    end

    assign operand = (op == OP_SLL) ? data_rev : data_in;
    assign acc_out = rev_flag ? acc_rev : acc;

    always_comb begin
        case (op)
            OP_SRL, OP_SLL: fill_sel = FILL_ZERO;
            OP_SRA:         fill_sel = FILL_SIGN;
            OP_ROTR:        fill_sel = FILL_ROT;
            default:        fill_sel = FILL_ZERO;
        endcase
    end

    // The top k bits come from the low k bits of hi_word, which is the
    // accumulator itself when rotating, so the shifted-out bits wrap around.
    always_comb begin
        k        = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
        k_comp   = WIDTH_W - {1'b0, k};
        rem_next = rem - k[SHAMT_WIDTH-1:0];
        case (mode)
            FILL_ROT:  hi_word = acc;
            FILL_SIGN: hi_word = fill_bit ? '1 : '0;
            default:   hi_word = '0;
        endcase
        shifted = (acc >> k) | (hi_word << k_comp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            result   <= '0;
            acc      <= '0;
            rem      <= '0;
            rev_flag <= 1'b0;
            mode     <= FILL_ZERO;
            fill_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= operand;
                        rev_flag <= (op == OP_SLL);
                        mode     <= fill_sel;
                        fill_bit <= data_in[DATA_WIDTH-1];
                        rem      <= shamt;
                        state    <= (shamt != '0) ? ST_SHIFT : ST_FINISH;
                    end
                end
                ST_SHIFT: begin
                    acc <= shifted;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    result <= acc_out;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: table of operations with hand-computed
// results and latencies, plus handshake and reset corner sequences.
module tb_shift_unit_seq;

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SLL  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        logic [4:0]  sh;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    shift_unit_seq #(
        .DATA_WIDTH(32),
        .SHAMT_WIDTH(5),
        .STEP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .data_in(data_in),
        .shamt(shamt),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called #1 after an edge; 'edges' counts the start-sampling edge as 1.
    task automatic wait_done(input int first, output int edges);
        edges = first;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done && edges < 64);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] exp, input int lat, input string nm);
        int edges;
        @(negedge clk);
        op = o; data_in = d; shamt = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; data_in = ~d; shamt = ~s;
        wait_done(1, edges);
        chk({nm, "_lat"}, 32'(edges), 32'(lat));
        chk({nm, "_res"}, result, exp);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int edges;
        logic saw_done;

        vecs[0]  = '{OP_SLL,  32'h00000001, 5'd31, 32'h80000000, 10};
        vecs[1]  = '{OP_SRA,  32'h80000000, 5'd4,  32'hF8000000, 3};
        vecs[2]  = '{OP_SRL,  32'h80000000, 5'd4,  32'h08000000, 3};
        vecs[3]  = '{OP_ROTR, 32'h12345678, 5'd8,  32'h78123456, 4};
        vecs[4]  = '{OP_SRL,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 2};
        vecs[5]  = '{OP_ROTR, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 2};
        vecs[6]  = '{OP_SRA,  32'h8000F000, 5'd31, 32'hFFFFFFFF, 10};
        vecs[7]  = '{OP_ROTR, 32'h00000001, 5'd1,  32'h80000000, 3};
        vecs[8]  = '{OP_SLL,  32'hF0000001, 5'd5,  32'h00000020, 4};
        vecs[9]  = '{OP_SRA,  32'h7FFFFFFF, 5'd3,  32'h0FFFFFFF, 3};
        vecs[10] = '{OP_ROTR, 32'h80000001, 5'd31, 32'h00000003, 10};
        vecs[11] = '{OP_SLL,  32'h12345678, 5'd16, 32'h56780000, 6};
        vecs[12] = '{OP_SRA,  32'h12345678, 5'd7,  32'h002468AC, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, result[29:0]}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].din, vecs[i].sh, vecs[i].exp, vecs[i].lat,
                   $sformatf("v%0d", i));
        end

        // Start pulses while busy must be dropped, not queued.
        @(negedge clk);
        op = OP_SRL; data_in = 32'h80000000; shamt = 5'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        op = OP_SLL; data_in = 32'hFFFFFFFF; shamt = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, edges);
        chk("busy_ign_lat", 32'(edges), 32'd4);
        chk("busy_ign_res", result, 32'h00800000);
        @(posedge clk); #1;
        chk("busy_ign_noqueue", {31'd0, busy}, 32'd0);

        // Start accepted in the done cycle.
        @(negedge clk);
        op = OP_SRL; data_in = 32'h000000F0; shamt = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, edges);
        chk("b2b_first", result, 32'h0000000F);
        op = OP_SLL; data_in = 32'h0000000F; shamt = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = '1; shamt = 5'd31;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(1, edges);
        chk("b2b_lat", 32'(edges), 32'd3);
        chk("b2b_res", result, 32'h000000F0);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        op = OP_ROTR; data_in = 32'h12345678; shamt = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Produce a nonzero result, then abort a long op at edge 5.
        run_op(OP_SRL, 32'h00000100, 5'd4, 32'h00000010, 3, "pre_abort");
        @(negedge clk);
        op = OP_SLL; data_in = 32'h00000001; shamt = 5'd31; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, result[29:0]}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_op(OP_SRL, 32'h00000010, 5'd4, 32'h00000001, 3, "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
